alu_shifter_pipe: RTL and testbench
===================================

ALU_SHIFTER_PIPE -- requirements
Module: alu_shifter_pipe

Interface
- REQ-001 The block SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
- REQ-002 The block SHALL have parameter STAGES, default 2, number of pipeline register stages; legal 1..$clog2(XLEN).
- REQ-003 The block SHALL have parameter TAGW, default 5, width of the pass-through tag (destination register index).
- REQ-004 clk  input  1  sole clock; all state on rising edge.
- REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-006 flush  input  1  synchronous kill of all in-flight operations.
- REQ-007 in_valid  input  1  operation offered.
- REQ-008 in_ready  output  1  block accepts operation this cycle.
- REQ-009 in_data  input  XLEN  operand to shift.
- REQ-010 in_shamt  input  XLEN  shift amount; only low $clog2(XLEN) bits used.
- REQ-011 in_type  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved.
- REQ-012 in_tag  input  TAGW  carried unchanged to output.
- REQ-013 out_valid  output  1  result available.
- REQ-014 out_ready  input  1  consumer takes result this cycle.
- REQ-015 out_data  output  XLEN  shift result.
- REQ-016 out_tag  output  TAGW  tag of the operation in out_data.

Function
- REQ-017 The block SHALL implement a log-shifter of $clog2(XLEN) levels (level k shifts by 2^k when shamt bit k set), split as evenly as possible over STAGES register stages, higher-index levels absorbing any remainder.
- REQ-018 The block SHALL mask shamt to its low $clog2(XLEN) bits (shamt 33 at XLEN=32 shifts by 1).
- REQ-019 SLL/SRL SHALL zero-fill; SRA SHALL replicate in_data[XLEN-1]; reserved types SHALL produce out_data 0 with out_valid asserted normally.
- REQ-020 An operation SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
- REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no back-pressure; throughput one operation per cycle.
- REQ-022 Each stage SHALL hold a valid bit; stage i SHALL load when stage i+1 is empty or advancing; in_ready SHALL equal (stage 0 empty) or (stage 0 advancing), with no combinational path from in_valid to in_ready.
- REQ-023 When out_ready is low with out_valid high, out_data/out_tag SHALL hold stable until transfer; no operation SHALL be dropped or duplicated.
- REQ-024 Simultaneous input and output transfer when full SHALL be accepted (pipeline advances one slot).
- REQ-025 flush SHALL clear every stage valid bit at the next edge, take priority over a same-cycle input transfer (input discarded), and drive in_ready low during the flush cycle.
- REQ-026 shamt 0 SHALL return in_data unchanged for every defined type.

Reset
- REQ-027 While rst_n low, all stage valid bits, out_valid SHALL be 0 and in_ready 0; data/tag registers SHALL reset to 0.
- REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations; in_ready SHALL rise the first cycle after rst_n deasserts.

Configuration
- REQ-029 With macro SHIFTER_ROTATE_EN defined, types 011/100 SHALL rotate left/right by masked shamt.
- REQ-030 Without SHIFTER_ROTATE_EN, 011/100 SHALL be treated as reserved (result 0) and no rotate logic instantiated.

Structure
- REQ-031 A shared package SHALL hold the shift-type enum (SHT_SLL..SHT_ROR) and the levels-per-stage computation function.
- REQ-032 One sub-module shifter_level SHALL implement a single log-level (parameter DIST) for all types; the top instantiates $clog2(XLEN) of them plus stage registers.

Verification
- REQ-033 XLEN=32, STAGES=2: SRA in_data 0x8000_0000 shamt 4 tag 7 -> after 2 cycles out_data 0xF800_0000, out_tag 7.
- REQ-034 SRL 0x8000_0000 shamt 36 -> out_data 0x0800_0000 (masked to 4); SLL 0x0000_0001 shamt 31 -> 0x8000_0000.
- REQ-035 Back-pressure: issue 4 back-to-back ops with out_ready low -> in_ready low after 2 accepted; release out_ready -> all 4 results in order, none lost.
- REQ-036 flush in cycle with 2 in flight and in_valid high -> out_valid stays 0 next cycles, next op after flush completes in 2 cycles.
- REQ-037 SHIFTER_ROTATE_EN defined: ROR 0x0000_00F1 shamt 4 -> 0x1000_000F; undefined: same stimulus -> 0x0000_0000.
- REQ-038 rst_n pulsed low with 2 ops in flight -> out_valid 0 immediately, no stale result after release.

Source files
------------

// File: rtl/alu_shifter_pipe_pkg.sv
// Shared types and stage-split helpers for the pipelined barrel shifter.
package alu_shifter_pipe_pkg;

  typedef enum logic [2:0] {
    SHT_SLL = 3'b000,
    SHT_SRL = 3'b001,
    SHT_SRA = 3'b010,
    SHT_ROL = 3'b011,
    SHT_ROR = 3'b100
  } sht_e;

  // Even split of log levels over stages; the last (levels % stages) stages take one extra.
  function automatic int levels_per_stage(int s, int levels, int stages);
    return levels / stages + ((s >= stages - (levels % stages)) ? 1 : 0);
  endfunction

  function automatic int first_level(int s, int levels, int stages);
    int acc = 0;
    for (int j = 0; j < s; j++) acc += levels_per_stage(j, levels, stages);
    return acc;
  endfunction

  function automatic int stage_of_level(int k, int levels, int stages);
    int st = 0;
    for (int j = 0; j < stages; j++)
      if (k >= first_level(j, levels, stages)) st = j;
    return st;
  endfunction

endpackage

// File: rtl/alu_shifter_pipe_level.sv
// One log-shifter level: shifts/rotates by DIST when en is set.
// Rotates exist only when SHIFTER_ROTATE_EN is defined; otherwise they act as reserved.
module shifter_level
  import alu_shifter_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DIST = 1
) (
  input  logic            en,
  input  logic [2:0]      typ,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  // Reserved types zero at every level, so the result is 0 regardless of shamt.
  always_comb begin
    dout = '0;
    case (typ)
      SHT_SLL: dout = en ? (din << DIST) : din;
      SHT_SRL: dout = en ? (din >> DIST) : din;
      SHT_SRA: dout = en ? XLEN'($signed(din) >>> DIST) : din;
`ifdef SHIFTER_ROTATE_EN
      SHT_ROL: dout = en ? ((din << DIST) | (din >> (XLEN - DIST))) : din;
      SHT_ROR: dout = en ? ((din >> DIST) | (din << (XLEN - DIST))) : din;
`endif
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/alu_shifter_pipe.sv
// Pipelined log shifter with valid/ready handshake, flush and pass-through tag.
// Optional rotate support via SHIFTER_ROTATE_EN.
module alu_shifter_pipe
  import alu_shifter_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic [XLEN-1:0] in_shamt,
  input  logic [2:0]      in_type,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [TAGW-1:0] out_tag
);

  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [SHW-1:0]  shamt;
    logic [2:0]      typ;
    logic [TAGW-1:0] tag;
  } stg_t;

  stg_t [STAGES-1:0] stg_q, stg_in, stg_d;
  logic [STAGES-1:0] vld_pipe, load, vld_src;
  logic [SHW-1:0][XLEN-1:0] lvl_in, lvl_out;
  logic unused_ok;

  // Stage i can load when some stage at or after it is empty, or the output drains.
  always_comb begin
    logic hole;
    hole    = out_ready;
    load    = '0;
    vld_src = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hole    = hole || !vld_pipe[i];
      load[i] = hole;
    end
    vld_src[0] = in_valid && in_ready;
    for (int i = 1; i < STAGES; i++) vld_src[i] = vld_pipe[i-1];
  end

  assign in_ready = rst_n && !flush && load[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    if (s == 0) begin : g_head
      assign stg_in[s] = '{data: in_data, shamt: in_shamt[SHW-1:0], typ: in_type, tag: in_tag};
    end else begin : g_body
      assign stg_in[s] = stg_q[s-1];
    end
    assign stg_d[s] = '{data:  lvl_out[first_level(s + 1, SHW, STAGES) - 1],
                        shamt: stg_in[s].shamt, typ: stg_in[s].typ, tag: stg_in[s].tag};
  end

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam int S = stage_of_level(k, SHW, STAGES);
    if (k == first_level(S, SHW, STAGES)) begin : g_first
      assign lvl_in[k] = stg_in[S].data;
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end
    shifter_level #(.XLEN(XLEN), .DIST(1 << k)) u_lvl (
      .en  (stg_in[S].shamt[k]),
      .typ (stg_in[S].typ),
      .din (lvl_in[k]),
      .dout(lvl_out[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      stg_q    <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush)        vld_pipe[s] <= 1'b0;
        else if (load[s]) vld_pipe[s] <= vld_src[s];
        if (load[s])      stg_q[s]    <= stg_d[s];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign out_data  = stg_q[STAGES-1].data;
  assign out_tag   = stg_q[STAGES-1].tag;

  // Upper shamt bits and already-consumed control fields are intentionally ignored.
  assign unused_ok = ^{in_shamt[XLEN-1:SHW], stg_q};

endmodule

// File: tb/tb_alu_shifter_pipe.sv
// Self-checking bench for alu_shifter_pipe (XLEN=32, STAGES=2) with a scoreboard model.
module tb_alu_shifter_pipe;
  localparam int XLEN = 32;
  localparam int TAGW = 5;
`ifdef SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] in_data, in_shamt, out_data;
  logic [2:0] in_type;
  logic [TAGW-1:0] in_tag, out_tag;
  int checks = 0, failures = 0;

  alu_shifter_pipe #(.XLEN(XLEN), .STAGES(2), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [31:0] sh, logic [2:0] t);
    int unsigned a = sh % 32;
    logic [63:0] dd = {d, d};
    case (t)
      3'd0: return d << a;
      3'd1: return d >> a;
      3'd2: return 32'($signed(d) >>> a);
      3'd3: return ROT ? dd[63-a -: 32] : 32'h0;
      3'd4: return ROT ? dd[a +: 32] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 0; flush = 0; in_valid = 1; out_ready = 1;
    in_data = 32'hFFFF_FFFF; in_shamt = 0; in_type = 0; in_tag = 5'h1F;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    checks++; if (out_tag !== 5'h0) begin failures++; $display("FAIL rst_out_tag got %h exp 0", out_tag); end
    in_valid = 0;
    rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] d[11], sh[11], ex[11];
    logic [2:0] ty[11];
    d  = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1, 32'hF1, 32'hF1, 32'hDEAD_BEEF,
           32'hA5A5_1234, 32'h8765_4321, 32'h8765_4321, 32'h1234_5678};
    sh = '{4, 36, 31, 33, 4, 4, 0, 0, 0, 32, 0};
    ty = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd4, 3'd3, 3'd5, 3'd0, 3'd2, 3'd1, 3'd4};
    ex = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h2,
           ROT ? 32'h1000_000F : 32'h0, ROT ? 32'h0000_0F10 : 32'h0, 32'h0,
           32'hA5A5_1234, 32'h8765_4321, 32'h8765_4321, ROT ? 32'h1234_5678 : 32'h0};
    out_ready = 1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      in_valid = 1; in_data = d[i]; in_shamt = sh[i]; in_type = ty[i];
      in_tag = (i == 0) ? 5'd7 : 5'(i);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready got %b exp 1", i, in_ready); end
      @(posedge clk); #1; in_valid = 0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early_valid got %b exp 0", i, out_valid); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ex[i] || out_tag !== ((i == 0) ? 5'd7 : 5'(i))) begin
        failures++;
        $display("FAIL dir%0d_result got v=%b d=%h t=%0d exp v=1 d=%h t=%0d", i, out_valid, out_data, out_tag,
                 ex[i], (i == 0) ? 7 : i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] od[4], osh[4], ed[4];
    logic [2:0] oty[4];
    int idx = 2, outs = 0, cyc = 0;
    bit got_in, got_out, first = 1;
    for (int i = 0; i < 4; i++) begin
      od[i] = $urandom; osh[i] = $urandom; oty[i] = 3'($urandom_range(0, 2));
      ed[i] = ref_shift(od[i], osh[i], oty[i]);
    end
    @(posedge clk); #1;
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = od[i]; in_shamt = osh[i]; in_type = oty[i]; in_tag = 5'(20 + i);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept%0d got %b exp 1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_data = od[2]; in_shamt = osh[2]; in_type = oty[2]; in_tag = 5'd22;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_in_ready got %b exp 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== ed[0] || out_tag !== 5'd20) begin
        failures++; $display("FAIL b2b_hold got v=%b d=%h t=%0d exp v=1 d=%h t=20", out_valid, out_data, out_tag, ed[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    while (outs < 4 && cyc < 20) begin
      @(negedge clk);
      got_in = in_valid && in_ready;
      got_out = out_valid && out_ready;
      if (first) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_full_passthru got %b exp 1", in_ready); end
        first = 0;
      end
      if (got_out) begin
        checks++;
        if (out_data !== ed[outs] || out_tag !== 5'(20 + outs)) begin
          failures++; $display("FAIL b2b_order%0d got d=%h t=%0d exp d=%h t=%0d", outs, out_data, out_tag, ed[outs], 20 + outs);
        end
        outs++;
      end
      @(posedge clk); #1;
      if (got_in) begin
        idx++;
        if (idx < 4) begin in_data = od[idx]; in_shamt = osh[idx]; in_type = oty[idx]; in_tag = 5'(20 + idx); end
        else in_valid = 0;
      end
      cyc++;
    end
    in_valid = 0;
    checks++; if (outs != 4) begin failures++; $display("FAIL b2b_count got %0d exp 4", outs); end
  endtask

  task automatic test_flush();
    logic [31:0] dd;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; in_data = 32'h1111_0000; in_shamt = 1; in_type = 0; in_tag = 1;
    @(posedge clk); #1;
    in_data = 32'h2222_0000; in_tag = 2;
    @(posedge clk); #1;
    flush = 1; in_data = 32'h3333_0000; in_tag = 3;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    @(posedge clk); #1;
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_killed%0d got %b exp 0", i, out_valid); end
    end
    @(posedge clk); #1;
    dd = $urandom;
    in_valid = 1; in_data = dd; in_shamt = 32'd13; in_type = 3'd2; in_tag = 9;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_next_early got %b exp 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_shift(dd, 13, 3'd2) || out_tag !== 5'd9) begin
      failures++; $display("FAIL flush_next got v=%b d=%h t=%0d exp v=1 d=%h t=9", out_valid, out_data, out_tag,
                           ref_shift(dd, 13, 3'd2));
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    out_ready = 1; in_valid = 1; in_data = 32'hCAFE_0001; in_shamt = 2; in_type = 0; in_tag = 4;
    @(posedge clk); #1;
    in_tag = 5;
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready got %b exp 0", in_ready); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_release_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale%0d got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [36:0] exp_q[$];
    logic [36:0] e;
    bit hold = 0;
    logic [31:0] hd;
    logic [4:0] ht;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      in_valid = ($urandom % 4) != 0; out_ready = ($urandom % 3) != 0; flush = ($urandom % 25) == 0;
      in_data = $urandom; in_shamt = $urandom; in_type = 3'($urandom); in_tag = 5'($urandom);
      @(negedge clk);
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
          failures++; $display("FAIL rnd_stable c%0d got v=%b d=%h t=%0d exp v=1 d=%h t=%0d", cyc, out_valid, out_data, out_tag, hd, ht);
        end
      end
      if (flush) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rnd_flush_ready c%0d got %b exp 0", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_spurious c%0d got d=%h t=%0d exp none", cyc, out_data, out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, out_data} !== e) begin
            failures++; $display("FAIL rnd_data c%0d got d=%h t=%0d exp d=%h t=%0d", cyc, out_data, out_tag, e[31:0], e[36:32]);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_tag, ref_shift(in_data, in_shamt, in_type)});
      hold = out_valid && !out_ready && !flush;
      hd = out_data; ht = out_tag;
    end
    @(posedge clk); #1;
    in_valid = 0; flush = 0; out_ready = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL drain_spurious got d=%h exp none", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, out_data} !== e) begin
            failures++; $display("FAIL drain_data got d=%h t=%0d exp d=%h t=%0d", out_data, out_tag, e[31:0], e[36:32]);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_lost got %0d pending exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
